mem_responder: RTL and testbench

// - Memory-side responder for the DataPath memory interface. It receives Read/Write requests

---
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder.sv | 122 ++++++++++++
 tb/tb_mem_responder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between the DataPath memory port and mem_responder.
// The master drives Read/Write/MAR/MDR; the slave returns Mdatain/Done/Busy/Err.
interface mem_responder_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              Read;
   logic              Write;
   logic [ADDR_W-1:0] MARaddr;
   logic [DATA_W-1:0] MDRdata;
   logic [DATA_W-1:0] Mdatain;
   logic              Done;
   logic              Busy;
   logic              Err;

   modport master (
      output Read, Write, MARaddr, MDRdata,
      input  Mdatain, Done, Busy, Err
   );

   modport slave (
      input  Read, Write, MARaddr, MDRdata,
      output Mdatain, Done, Busy, Err
   );
endinterface

// File: rtl/mem_responder.sv
// Single-port word RAM with wait states and a Done handshake for the DataPath.
// Define MEM_BOUNDS_CHECK_EN to flag addr >= DEPTH as illegal instead of wrapping.
module mem_responder #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 512,
   parameter int WAIT_CYCLES = 1
) (
   input logic             clock,
   input logic             clear,
   mem_responder_if.slave  bus_io
);
   localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);
   localparam logic [3:0]  WLAST   = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              wr_q;
   logic              both_q;
   logic              req_prev_q;
   logic [DATA_W-1:0] rdata_q;
   logic              done_q;
   logic              busy_q;
   logic              err_q;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              req;
   logic              start;
   logic              oob;
   logic              illegal;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] rd_word;

   assign req   = bus_io.Read | bus_io.Write;
   // Only a fresh rise of the request starts an access.
   assign start = req & ~req_prev_q;

`ifdef MEM_BOUNDS_CHECK_EN
   assign oob = 32'(addr_q) >= DEPTH_U;
   assign idx = IDX_W'(addr_q);
`else
   assign oob = 1'b0;
   assign idx = IDX_W'(32'(addr_q) % DEPTH_U);
`endif

   assign illegal = both_q | oob;
   assign rd_word = mem_q[idx];

   always_ff @(posedge clock) begin
      if (state_q == S_RESP && wr_q && !illegal) begin
         mem_q[idx] <= data_q;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wr_q       <= 1'b0;
         both_q     <= 1'b0;
         req_prev_q <= 1'b0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         req_prev_q <= req;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  addr_q  <= bus_io.MARaddr;
                  data_q  <= bus_io.MDRdata;
                  wr_q    <= bus_io.Write;
                  both_q  <= bus_io.Read & bus_io.Write;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               if (!req) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (cnt_q == WLAST) begin
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            S_RESP: begin
               if (!wr_q && !both_q) begin
                  rdata_q <= oob ? '0 : rd_word;
               end
               done_q  <= 1'b1;
               err_q   <= illegal;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus_io.Mdatain = rdata_q;
   assign bus_io.Done    = done_q;
   assign bus_io.Busy    = busy_q;
   assign bus_io.Err     = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances cover 1, 0 and 3 wait
// states plus a 256-word RAM on a 9-bit address for the out-of-range path.
module tb_mem_responder;
   logic       clk;
   logic [3:0] clr;
   int         total;
   int         passed;

   mem_responder_if #(.ADDR_W(9), .DATA_W(32)) if0 ();
   mem_responder_if #(.ADDR_W(9), .DATA_W(32)) if1 ();
   mem_responder_if #(.ADDR_W(9), .DATA_W(32)) if2 ();
   mem_responder_if #(.ADDR_W(9), .DATA_W(32)) if3 ();

   mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(1)) u0 (
      .clock(clk), .clear(clr[0]), .bus_io(if0.slave));
   mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(0)) u1 (
      .clock(clk), .clear(clr[1]), .bus_io(if1.slave));
   mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(3)) u2 (
      .clock(clk), .clear(clr[2]), .bus_io(if2.slave));
   mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(1)) u3 (
      .clock(clk), .clear(clr[3]), .bus_io(if3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int u, input logic r, input logic w,
                        input logic [8:0] a, input logic [31:0] d);
      case (u)
         0: begin if0.Read = r; if0.Write = w; if0.MARaddr = a; if0.MDRdata = d; end
         1: begin if1.Read = r; if1.Write = w; if1.MARaddr = a; if1.MDRdata = d; end
         2: begin if2.Read = r; if2.Write = w; if2.MARaddr = a; if2.MDRdata = d; end
         default: begin if3.Read = r; if3.Write = w; if3.MARaddr = a; if3.MDRdata = d; end
      endcase
   endtask

   // {Done, Busy, Err, Mdatain}
   function automatic logic [34:0] obs(input int u);
      case (u)
         0:       return {if0.Done, if0.Busy, if0.Err, if0.Mdatain};
         1:       return {if1.Done, if1.Busy, if1.Err, if1.Mdatain};
         2:       return {if2.Done, if2.Busy, if2.Err, if2.Mdatain};
         default: return {if3.Done, if3.Busy, if3.Err, if3.Mdatain};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Raise a request, wait for Done, check latency/Err/Mdatain, then drop it.
   task automatic access(input int u, input string tag, input logic r, input logic w,
                         input logic [8:0] a, input logic [31:0] d, input int lat,
                         input logic [31:0] exp_data, input logic exp_err, input bit chg);
      int          n;
      bit          seen;
      logic [34:0] o;
      drive(u, r, w, a, d);
      n    = 0;
      seen = 1'b0;
      o    = '0;
      while (!seen && n < 20) begin
         tick();
         n++;
         o = obs(u);
         if (n == 1) begin
            chk({tag, ".busy_acc"}, 32'(o[33]), 32'd1);
            if (chg) drive(u, r, w, a + 9'd1, ~d);
         end
         if (o[34]) seen = 1'b1;
      end
      chk({tag, ".lat"}, 32'(n), 32'(lat));
      chk({tag, ".err"}, 32'(o[32]), 32'(exp_err));
      chk({tag, ".busy_done"}, 32'(o[33]), 32'd0);
      chk({tag, ".data"}, o[31:0], exp_data);
      drive(u, 1'b0, 1'b0, '0, '0);
      tick();
      o = obs(u);
      chk({tag, ".done_pulse"}, 32'(o[34]), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [34:0] o;
      int          dn;
      total  = 0;
      passed = 0;
      clr    = 4'h0;
      for (int u = 0; u < 4; u++) drive(u, 1'b0, 1'b0, '0, '0);
      #12;
      o = obs(0);
      chk("rst.done", 32'(o[34]), 32'd0);
      chk("rst.busy", 32'(o[33]), 32'd0);
      chk("rst.err", 32'(o[32]), 32'd0);
      chk("rst.mdat", o[31:0], 32'd0);
      clr = 4'hF;
      tick();

      // one wait state
      access(0, "w010", 1'b0, 1'b1, 9'h010, 32'h0000_0022, 3, 32'h0, 1'b0, 1'b0);
      access(0, "w011", 1'b0, 1'b1, 9'h011, 32'h0000_0033, 3, 32'h0, 1'b0, 1'b0);
      access(0, "r010", 1'b1, 1'b0, 9'h010, 32'h0, 3, 32'h0000_0022, 1'b0, 1'b0);
      access(0, "r011", 1'b1, 1'b0, 9'h011, 32'h0, 3, 32'h0000_0033, 1'b0, 1'b0);
      access(0, "r010chg", 1'b1, 1'b0, 9'h010, 32'h0, 3, 32'h0000_0022, 1'b0, 1'b1);
      access(0, "w020", 1'b0, 1'b1, 9'h020, 32'hCAFE_0020, 3, 32'h0000_0022, 1'b0, 1'b0);
      access(0, "rw020", 1'b1, 1'b1, 9'h020, 32'hDEAD_BEEF, 3, 32'h0000_0022, 1'b1, 1'b0);
      access(0, "r020", 1'b1, 1'b0, 9'h020, 32'h0, 3, 32'hCAFE_0020, 1'b0, 1'b0);

      // request held past Done must not restart
      drive(0, 1'b1, 1'b0, 9'h011, 32'h0);
      tick(); tick(); tick();
      o = obs(0);
      chk("b2b.done", 32'(o[34]), 32'd1);
      chk("b2b.data", o[31:0], 32'h0000_0033);
      dn = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         o = obs(0);
         dn += int'(o[34]) + int'(o[33]);
      end
      chk("b2b.held_idle", 32'(dn), 32'd0);
      drive(0, 1'b0, 1'b0, '0, '0);
      tick();

      // reset during a write in its access cycle
      access(0, "w030", 1'b0, 1'b1, 9'h030, 32'h1111_1111, 3, 32'h0000_0033, 1'b0, 1'b0);
      drive(0, 1'b0, 1'b1, 9'h030, 32'h2222_2222);
      tick(); tick();
      o = obs(0);
      chk("rstmid.busy_before", 32'(o[33]), 32'd1);
      #1 clr[0] = 1'b0;
      #1 o = obs(0);
      chk("rstmid.mdat", o[31:0], 32'd0);
      chk("rstmid.busy", 32'(o[33]), 32'd0);
      chk("rstmid.done", 32'(o[34]), 32'd0);
      drive(0, 1'b0, 1'b0, '0, '0);
      tick();
      clr[0] = 1'b1;
      tick();
      access(0, "r030", 1'b1, 1'b0, 9'h030, 32'h0, 3, 32'h1111_1111, 1'b0, 1'b0);

      // zero wait states
      access(1, "z.w000", 1'b0, 1'b1, 9'h000, 32'h5A1B_8000, 2, 32'h0, 1'b0, 1'b0);
      access(1, "z.r000", 1'b1, 1'b0, 9'h000, 32'h0, 2, 32'h5A1B_8000, 1'b0, 1'b0);

      // three wait states and abort during WAIT
      access(2, "t.w005", 1'b0, 1'b1, 9'h005, 32'h0000_0077, 5, 32'h0, 1'b0, 1'b0);
      access(2, "t.w006", 1'b0, 1'b1, 9'h006, 32'h0000_0088, 5, 32'h0, 1'b0, 1'b0);
      access(2, "t.r005", 1'b1, 1'b0, 9'h005, 32'h0, 5, 32'h0000_0077, 1'b0, 1'b0);
      drive(2, 1'b1, 1'b0, 9'h006, 32'h0);
      tick();
      o = obs(2);
      chk("abort.busy_acc", 32'(o[33]), 32'd1);
      drive(2, 1'b0, 1'b0, '0, '0);
      tick();
      o = obs(2);
      chk("abort.busy_drop", 32'(o[33]), 32'd0);
      dn = int'(o[34]);
      for (int i = 0; i < 6; i++) begin
         tick();
         o = obs(2);
         dn += int'(o[34]);
      end
      chk("abort.no_done", 32'(dn), 32'd0);
      chk("abort.mdat", o[31:0], 32'h0000_0077);

      // 256-word RAM addressed past its end
      access(3, "d.w0FF", 1'b0, 1'b1, 9'h0FF, 32'hABCD_00FF, 3, 32'h0, 1'b0, 1'b0);
`ifdef MEM_BOUNDS_CHECK_EN
      access(3, "d.r1FF", 1'b1, 1'b0, 9'h1FF, 32'h0, 3, 32'h0, 1'b1, 1'b0);
`else
      access(3, "d.r1FF", 1'b1, 1'b0, 9'h1FF, 32'h0, 3, 32'hABCD_00FF, 1'b0, 1'b0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
